// File: rtl/cpu_fde_pipeline.sv
// Three-stage fetch/decode/execute pipeline for a Moxie ISA subset; the register file is external.
// Optional build macro CPU_FDE_MUL_EN enables mul.l (op 0x2f).
module cpu_fde_pipeline #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] imem_address_o,
  input  logic [47:0] imem_data_i,
  output logic        reg_read_enable_o,
  output logic [3:0]  reg_read_index1_o,
  output logic [3:0]  reg_read_index2_o,
  input  logic [31:0] reg_value1_i,
  input  logic [31:0] reg_value2_i,
  output logic        reg_write_enable_o,
  output logic [3:0]  reg_write_index_o,
  output logic [31:0] reg_write_value_o,
  output logic        stall_o
);

  localparam logic [7:0] OP_LDI  = 8'h01;
  localparam logic [7:0] OP_MOV  = 8'h02;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_AND  = 8'h26;
  localparam logic [7:0] OP_LSHR = 8'h27;
  localparam logic [7:0] OP_ASHL = 8'h28;
  localparam logic [7:0] OP_SUB  = 8'h29;
  localparam logic [7:0] OP_NEG  = 8'h2a;
  localparam logic [7:0] OP_OR   = 8'h2b;
  localparam logic [7:0] OP_NOT  = 8'h2c;
  localparam logic [7:0] OP_ASHR = 8'h2d;
  localparam logic [7:0] OP_XOR  = 8'h2e;
`ifdef CPU_FDE_MUL_EN
  localparam logic [7:0] OP_MUL  = 8'h2f;
`endif

  // Fetch stage state
  logic [31:0] pc_q, pc_d;
  logic        f_valid_q;
  logic [15:0] f_opcode_q;
  logic [31:0] f_operand_q;

  // Decode stage state
  logic        dec_valid_q;
  logic [7:0]  dec_op_q;
  logic [3:0]  dec_ra_q, dec_rb_q;
  logic        dec_rd_a_q, dec_rd_a_d;
  logic        dec_rd_b_q, dec_rd_b_d;
  logic        dec_we_q, dec_we_d;
  logic [31:0] dec_operand_q;

  // Execute results, registered as the write-back port
  logic        wb_we_q, wb_we_d;
  logic [3:0]  wb_idx_q;
  logic [31:0] wb_val_q, wb_val_d;

  logic        stall;
  logic signed [31:0] op_a_s;
  logic [31:0] op_a, op_b;
  logic [4:0]  shamt;

  assign pc_d = pc_q + ((imem_data_i[47:40] == OP_LDI) ? 32'd6 : 32'd2);

  always_comb begin
    dec_rd_a_d = 1'b0;
    dec_rd_b_d = 1'b0;
    dec_we_d   = 1'b0;
    if (f_valid_q && !f_opcode_q[15]) begin
      case (f_opcode_q[15:8])
        OP_LDI: dec_we_d = 1'b1;
        OP_MOV, OP_NEG, OP_NOT: begin
          dec_rd_b_d = 1'b1;
          dec_we_d   = 1'b1;
        end
        OP_ADD, OP_AND, OP_LSHR, OP_ASHL, OP_SUB,
        OP_OR, OP_ASHR, OP_XOR: begin
          dec_rd_a_d = 1'b1;
          dec_rd_b_d = 1'b1;
          dec_we_d   = 1'b1;
        end
`ifdef CPU_FDE_MUL_EN
        OP_MUL: begin
          dec_rd_a_d = 1'b1;
          dec_rd_b_d = 1'b1;
          dec_we_d   = 1'b1;
        end
`endif
        default: begin
          dec_rd_a_d = 1'b0;
          dec_rd_b_d = 1'b0;
          dec_we_d   = 1'b0;
        end
      endcase
    end
  end

  // The external regfile commits wb_* at the end of this cycle, so a read of that index now is stale.
  assign stall = (dec_rd_a_q && wb_we_q && (dec_ra_q == wb_idx_q)) ||
                 (dec_rd_b_q && wb_we_q && (dec_rb_q == wb_idx_q));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q          <= RESET_PC;
      f_valid_q     <= 1'b0;
      f_opcode_q    <= 16'h0;
      f_operand_q   <= 32'h0;
      dec_valid_q   <= 1'b0;
      dec_op_q      <= 8'h0;
      dec_ra_q      <= 4'h0;
      dec_rb_q      <= 4'h0;
      dec_rd_a_q    <= 1'b0;
      dec_rd_b_q    <= 1'b0;
      dec_we_q      <= 1'b0;
      dec_operand_q <= 32'h0;
    end else if (!stall) begin
      pc_q          <= pc_d;
      f_valid_q     <= 1'b1;
      f_opcode_q    <= imem_data_i[47:32];
      f_operand_q   <= imem_data_i[31:0];
      dec_valid_q   <= f_valid_q;
      dec_op_q      <= f_opcode_q[15:8];
      dec_ra_q      <= f_opcode_q[7:4];
      dec_rb_q      <= f_opcode_q[3:0];
      dec_rd_a_q    <= dec_rd_a_d;
      dec_rd_b_q    <= dec_rd_b_d;
      dec_we_q      <= dec_we_d;
      dec_operand_q <= f_operand_q;
    end
  end

  assign op_a   = reg_value1_i;
  assign op_a_s = reg_value1_i;
  assign op_b   = reg_value2_i;
  assign shamt  = reg_value2_i[4:0];

  always_comb begin
    wb_val_d = 32'h0;
    case (dec_op_q)
      OP_LDI:  wb_val_d = dec_operand_q;
      OP_MOV:  wb_val_d = op_b;
      OP_ADD:  wb_val_d = op_a + op_b;
      OP_AND:  wb_val_d = op_a & op_b;
      OP_LSHR: wb_val_d = op_a >> shamt;
      OP_ASHL: wb_val_d = op_a << shamt;
      OP_SUB:  wb_val_d = op_a - op_b;
      OP_NEG:  wb_val_d = 32'h0 - op_b;
      OP_OR:   wb_val_d = op_a | op_b;
      OP_NOT:  wb_val_d = ~op_b;
      OP_ASHR: wb_val_d = $unsigned(op_a_s >>> shamt);
      OP_XOR:  wb_val_d = op_a ^ op_b;
`ifdef CPU_FDE_MUL_EN
      OP_MUL:  wb_val_d = op_a * op_b;
`endif
      default: wb_val_d = 32'h0;
    endcase
  end

  // A stalled decode slot enters execute as a bubble
  assign wb_we_d = dec_valid_q && dec_we_q && !stall;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wb_we_q  <= 1'b0;
      wb_idx_q <= 4'h0;
      wb_val_q <= 32'h0;
    end else begin
      wb_we_q  <= wb_we_d;
      wb_idx_q <= dec_ra_q;
      wb_val_q <= wb_val_d;
    end
  end

  assign imem_address_o     = pc_q;
  assign reg_read_enable_o  = dec_rd_a_q || dec_rd_b_q;
  assign reg_read_index1_o  = dec_ra_q;
  assign reg_read_index2_o  = dec_rb_q;
  assign reg_write_enable_o = wb_we_q;
  assign reg_write_index_o  = wb_idx_q;
  assign reg_write_value_o  = wb_val_q;
  assign stall_o            = stall;

endmodule

// File: tb/tb_cpu_fde_pipeline.sv
// Bench for cpu_fde_pipeline: directed scenarios plus random programs checked
// against an instruction-level model with an external register file model.
module tb_cpu_fde_pipeline;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] imem_address_o;
  logic [47:0] imem_data_i;
  logic        reg_read_enable_o;
  logic [3:0]  reg_read_index1_o, reg_read_index2_o;
  logic [31:0] reg_value1_i, reg_value2_i;
  logic        reg_write_enable_o;
  logic [3:0]  reg_write_index_o;
  logic [31:0] reg_write_value_o;
  logic        stall_o;

  cpu_fde_pipeline #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_address_o(imem_address_o), .imem_data_i(imem_data_i),
    .reg_read_enable_o(reg_read_enable_o),
    .reg_read_index1_o(reg_read_index1_o), .reg_read_index2_o(reg_read_index2_o),
    .reg_value1_i(reg_value1_i), .reg_value2_i(reg_value2_i),
    .reg_write_enable_o(reg_write_enable_o), .reg_write_index_o(reg_write_index_o),
    .reg_write_value_o(reg_write_value_o), .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [15:0] op;
    logic [31:0] imm;
  } instr_t;

  logic [15:0] mem_op  [0:511];
  logic [31:0] mem_imm [0:511];
  logic [31:0] regs      [0:15];
  logic [31:0] init_regs [0:15];
  logic [31:0] exp_regs  [0:15];
  instr_t      prog [$];
  logic [35:0] obs_q [$];
  logic [35:0] exp_q [$];
  int          stall_cnt;
  int          exp_stalls;
  int          vectors = 0;
  int          miscompares = 0;

  assign imem_data_i  = (imem_address_o < 32'd1024) ?
                        {mem_op[imem_address_o[9:1]], mem_imm[imem_address_o[9:1]]} :
                        {16'h0f00, 32'h0};
  assign reg_value1_i = regs[reg_read_index1_o];
  assign reg_value2_i = regs[reg_read_index2_o];

  // External register file: preloaded while in reset, written by the write-back port
  always @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 16; i++) regs[i] <= init_regs[i];
    end else if (reg_write_enable_o) begin
      regs[reg_write_index_o] <= reg_write_value_o;
    end
  end

  always @(negedge clk_i) begin
    if (!rst_i) begin
      obs_q.delete();
      stall_cnt = 0;
    end else begin
      if (reg_write_enable_o) obs_q.push_back({reg_write_index_o, reg_write_value_o});
      if (stall_o) stall_cnt++;
    end
  end

  task automatic load_mem();
    logic [31:0] addr;
    for (int i = 0; i < 512; i++) begin
      mem_op[i]  = 16'h0f00;
      mem_imm[i] = 32'h0;
    end
    addr = 32'h0;
    foreach (prog[k]) begin
      mem_op[addr[9:1]]  = prog[k].op;
      mem_imm[addr[9:1]] = prog[k].imm;
      addr = addr + ((prog[k].op[15:8] == 8'h01) ? 32'd6 : 32'd2);
    end
  endtask

  task automatic reset_and_release();
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  function automatic void op_class(input logic [15:0] op, output bit ra, output bit rb, output bit we);
    ra = 0; rb = 0; we = 0;
    if (!op[15]) begin
      case (op[15:8])
        8'h01: we = 1;
        8'h02, 8'h2a, 8'h2c: begin rb = 1; we = 1; end
        8'h05, 8'h26, 8'h27, 8'h28, 8'h29, 8'h2b, 8'h2d, 8'h2e: begin ra = 1; rb = 1; we = 1; end
`ifdef CPU_FDE_MUL_EN
        8'h2f: begin ra = 1; rb = 1; we = 1; end
`endif
        default: ;
      endcase
    end
  endfunction

  // Sequential instruction-set model; a stall is expected whenever an instruction
  // reads the register written by the instruction immediately before it.
  task automatic run_model();
    bit prev_we, ra, rb, we;
    logic [3:0] prev_idx, ia, ib;
    logic [31:0] a, b, v;
    for (int i = 0; i < 16; i++) exp_regs[i] = init_regs[i];
    exp_q.delete();
    exp_stalls = 0;
    prev_we = 0;
    prev_idx = 4'h0;
    foreach (prog[k]) begin
      op_class(prog[k].op, ra, rb, we);
      ia = prog[k].op[7:4];
      ib = prog[k].op[3:0];
      a = exp_regs[ia];
      b = exp_regs[ib];
      if (prev_we && ((ra && ia == prev_idx) || (rb && ib == prev_idx))) exp_stalls++;
      case (prog[k].op[15:8])
        8'h01: v = prog[k].imm;
        8'h02: v = b;
        8'h05: v = a + b;
        8'h26: v = a & b;
        8'h27: v = a >> b[4:0];
        8'h28: v = a << b[4:0];
        8'h29: v = a - b;
        8'h2a: v = -b;
        8'h2b: v = a | b;
        8'h2c: v = ~b;
        8'h2d: v = 32'($signed(a) >>> b[4:0]);
        8'h2e: v = a ^ b;
        8'h2f: v = a * b;
        default: v = 32'h0;
      endcase
      if (we) begin
        exp_regs[ia] = v;
        exp_q.push_back({ia, v});
      end
      prev_we = we;
      prev_idx = ia;
    end
  endtask

  function automatic instr_t rand_instr();
    instr_t r;
    logic [7:0] op;
    case ($urandom_range(0, 16))
      0: op = 8'h01;  1: op = 8'h02;  2: op = 8'h05;  3: op = 8'h26;
      4: op = 8'h27;  5: op = 8'h28;  6: op = 8'h29;  7: op = 8'h2a;
      8: op = 8'h2b;  9: op = 8'h2c;  10: op = 8'h2d; 11: op = 8'h2e;
      12: op = 8'h2f; 13: op = 8'h0f; 14: op = 8'h10;
      15: op = 8'h80 | 8'($urandom_range(0, 127));
      default: op = 8'h01;
    endcase
    r.op  = {op, 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
    r.imm = $urandom();
    return r;
  endfunction

  task automatic test_reset();
    prog.delete();
    for (int i = 0; i < 16; i++) init_regs[i] = 32'h0;
    load_mem();
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    vectors++;
    if (imem_address_o !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h expected %h", imem_address_o, 32'h0); end
    vectors++;
    if (reg_write_enable_o !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b expected 0", reg_write_enable_o); end
    vectors++;
    if (stall_o !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b expected 0", stall_o); end
    rst_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (imem_address_o !== 32'(2 * k)) begin
        miscompares++; $display("FAIL nop_seq[%0d]: got %h expected %h", k, imem_address_o, 32'(2 * k));
      end
      @(negedge clk_i);
    end
  endtask

  task automatic test_ldi();
    prog.delete();
    prog.push_back('{op: 16'h0130, imm: 32'h1234_5678});
    load_mem();
    reset_and_release();
    @(negedge clk_i);
    vectors++;
    if (imem_address_o !== 32'h6) begin miscompares++; $display("FAIL ldi_next_pc: got %h expected 6", imem_address_o); end
    @(negedge clk_i);
    vectors++;
    if (reg_write_enable_o !== 1'b0) begin miscompares++; $display("FAIL ldi_early_we: got %b expected 0", reg_write_enable_o); end
    @(negedge clk_i);
    vectors++;
    if ({reg_write_enable_o, reg_write_index_o, reg_write_value_o} !== {1'b1, 4'd3, 32'h1234_5678}) begin
      miscompares++;
      $display("FAIL ldi_wb: got we=%b idx=%0d val=%h expected we=1 idx=3 val=12345678",
               reg_write_enable_o, reg_write_index_o, reg_write_value_o);
    end
  endtask

  task automatic test_alu_one(input string name, input logic [7:0] op, input logic [31:0] a,
                              input logic [31:0] b, input bit exp_we, input logic [31:0] exp_val);
    prog.delete();
    prog.push_back('{op: {op, 4'd1, 4'd2}, imm: $urandom()});
    for (int i = 0; i < 16; i++) init_regs[i] = $urandom();
    init_regs[1] = a;
    init_regs[2] = b;
    load_mem();
    reset_and_release();
    repeat (8) @(negedge clk_i);
    vectors++;
    if (obs_q.size() !== (exp_we ? 1 : 0)) begin
      miscompares++; $display("FAIL %s_count: got %0d writes expected %0d", name, obs_q.size(), exp_we ? 1 : 0);
    end else if (exp_we) begin
      vectors++;
      if (obs_q[0] !== {4'd1, exp_val}) begin
        miscompares++; $display("FAIL %s: got %h expected %h", name, obs_q[0], {4'd1, exp_val});
      end
    end
  endtask

  task automatic test_alu();
    test_alu_one("add",  8'h05, 32'hFFFF_FFFF, 32'h1, 1, 32'h0);
    test_alu_one("sub",  8'h29, 32'hFFFF_FFFF, 32'h1, 1, 32'hFFFF_FFFE);
    test_alu_one("ashr", 8'h2d, 32'hFFFF_FFFF, 32'h4, 1, 32'hFFFF_FFFF);
    test_alu_one("lshr", 8'h27, 32'hFFFF_FFFF, 32'h4, 1, 32'h0FFF_FFFF);
    test_alu_one("ashl", 8'h28, 32'h0000_0001, 32'd35, 1, 32'h0000_0008);
    test_alu_one("neg",  8'h2a, 32'h1234_0000, 32'h1, 1, 32'hFFFF_FFFF);
    test_alu_one("not",  8'h2c, 32'h0, 32'h0F0F_0000, 1, 32'hF0F0_FFFF);
    test_alu_one("mov",  8'h02, 32'h0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);
`ifdef CPU_FDE_MUL_EN
    test_alu_one("mul",  8'h2f, 32'h0001_0000, 32'h0001_0001, 1, 32'h0001_0000);
`else
    test_alu_one("mul",  8'h2f, 32'h0001_0000, 32'h0001_0001, 0, 32'h0);
`endif
    test_alu_one("nop",  8'h0f, 32'h5, 32'h6, 0, 32'h0);
    test_alu_one("undef", 8'h10, 32'h5, 32'h6, 0, 32'h0);
    test_alu_one("form2", 8'h85, 32'h5, 32'h6, 0, 32'h0);
  endtask

  task automatic test_hazard();
    prog.delete();
    prog.push_back('{op: 16'h0140, imm: 32'd5});
    prog.push_back('{op: 16'h0554, imm: 32'h0});
    for (int i = 0; i < 16; i++) init_regs[i] = 32'h0;
    init_regs[5] = 32'd10;
    load_mem();
    reset_and_release();
    repeat (2) @(negedge clk_i);
    vectors++;
    if (stall_o !== 1'b0) begin miscompares++; $display("FAIL haz_pre: got %b expected 0", stall_o); end
    @(negedge clk_i);
    vectors++;
    if ({stall_o, imem_address_o} !== {1'b1, 32'hA}) begin
      miscompares++; $display("FAIL haz_stall: got stall=%b pc=%h expected stall=1 pc=a", stall_o, imem_address_o);
    end
    vectors++;
    if ({reg_write_enable_o, reg_write_index_o, reg_write_value_o} !== {1'b1, 4'd4, 32'd5}) begin
      miscompares++; $display("FAIL haz_wb_r4: got we=%b idx=%0d val=%h expected we=1 idx=4 val=5",
                              reg_write_enable_o, reg_write_index_o, reg_write_value_o);
    end
    @(negedge clk_i);
    vectors++;
    if ({stall_o, imem_address_o} !== {1'b0, 32'hA}) begin
      miscompares++; $display("FAIL haz_hold: got stall=%b pc=%h expected stall=0 pc=a", stall_o, imem_address_o);
    end
    @(negedge clk_i);
    vectors++;
    if ({reg_write_enable_o, reg_write_index_o, reg_write_value_o, imem_address_o} !== {1'b1, 4'd5, 32'd15, 32'hC}) begin
      miscompares++; $display("FAIL haz_add: got we=%b idx=%0d val=%h pc=%h expected we=1 idx=5 val=f pc=c",
                              reg_write_enable_o, reg_write_index_o, reg_write_value_o, imem_address_o);
    end
    repeat (4) @(negedge clk_i);
    vectors++;
    if (stall_cnt !== 1) begin miscompares++; $display("FAIL haz_cycles: got %0d expected 1", stall_cnt); end
  endtask

  task automatic test_no_false_stall();
    prog.delete();
    prog.push_back('{op: 16'h0140, imm: 32'd5});
    prog.push_back('{op: 16'h0267, imm: 32'h0});
    prog.push_back('{op: 16'h0f00, imm: 32'h0});
    prog.push_back('{op: 16'h0140, imm: 32'd7});
    prog.push_back('{op: 16'h0140, imm: 32'd9});
    for (int i = 0; i < 16; i++) init_regs[i] = $urandom();
    load_mem();
    reset_and_release();
    run_model();
    repeat (14) @(negedge clk_i);
    vectors++;
    if (stall_cnt !== 0) begin miscompares++; $display("FAIL nostall_count: got %0d expected 0", stall_cnt); end
    vectors++;
    if (obs_q.size() !== exp_q.size()) begin
      miscompares++; $display("FAIL nostall_writes: got %0d expected %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[k]) begin
        vectors++;
        if (obs_q[k] !== exp_q[k]) begin
          miscompares++; $display("FAIL nostall_wb[%0d]: got %h expected %h", k, obs_q[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      prog.delete();
      for (int k = 0; k < 30; k++) prog.push_back(rand_instr());
      for (int i = 0; i < 16; i++) init_regs[i] = $urandom();
      load_mem();
      reset_and_release();
      run_model();
      repeat (prog.size() + exp_stalls + 10) @(negedge clk_i);
      vectors++;
      if (stall_cnt !== exp_stalls) begin
        miscompares++; $display("FAIL rnd%0d_stalls: got %0d expected %0d", it, stall_cnt, exp_stalls);
      end
      vectors++;
      if (obs_q.size() !== exp_q.size()) begin
        miscompares++; $display("FAIL rnd%0d_writes: got %0d expected %0d", it, obs_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[k]) begin
          vectors++;
          if (obs_q[k] !== exp_q[k]) begin
            miscompares++; $display("FAIL rnd%0d_wb[%0d]: got %h expected %h", it, k, obs_q[k], exp_q[k]);
          end
        end
      end
      for (int i = 0; i < 16; i++) begin
        vectors++;
        if (regs[i] !== exp_regs[i]) begin
          miscompares++; $display("FAIL rnd%0d_r%0d: got %h expected %h", it, i, regs[i], exp_regs[i]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    prog.delete();
    for (int k = 0; k < 20; k++) prog.push_back(rand_instr());
    for (int i = 0; i < 16; i++) init_regs[i] = $urandom();
    load_mem();
    reset_and_release();
    repeat (7) @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    vectors++;
    if ({imem_address_o, reg_write_enable_o, stall_o, reg_read_enable_o} !== {32'h0, 3'b000}) begin
      miscompares++; $display("FAIL midrst_state: got pc=%h we=%b stall=%b re=%b expected pc=0 we=0 stall=0 re=0",
                              imem_address_o, reg_write_enable_o, stall_o, reg_read_enable_o);
    end
    prog.delete();
    prog.push_back('{op: 16'h0170, imm: 32'hCAFE_BABE});
    load_mem();
    reset_and_release();
    repeat (8) @(negedge clk_i);
    vectors++;
    if (obs_q.size() !== 1) begin
      miscompares++; $display("FAIL midrst_count: got %0d expected 1", obs_q.size());
    end else begin
      vectors++;
      if (obs_q[0] !== {4'd7, 32'hCAFE_BABE}) begin
        miscompares++; $display("FAIL midrst_wb: got %h expected %h", obs_q[0], {4'd7, 32'hCAFE_BABE});
      end
    end
  endtask

  initial begin
    rst_i = 1'b0;
    test_reset();
    test_ldi();
    test_alu();
    test_hazard();
    test_no_false_stall();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_fde_pipeline.md
Name: cpu_fde_pipeline

Overview:
- Three-stage in-order integer pipeline (fetch, decode, execute) for a subset of the Moxie ISA.
- The register file sits outside this block: the block drives two read indices and one write-back port, and reads values back combinationally.
- Includes read-after-writeback hazard detection with stall and bubble insertion.

Parameters:
- RESET_PC, 32'h0000_0000, first instruction address after reset.

Ports:
- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  reset, asynchronous, active-low
- imem_address_o  output  32  instruction fetch address (PC)
- imem_data_i  input  48  combinational fetch data: [47:32] opcode, [31:0] following 32-bit word
- reg_read_enable_o  output  1  either read index in use
- reg_read_index1_o  output  4  regA index
- reg_read_index2_o  output  4  regB index
- reg_value1_i  input  32  combinational value of index1
- reg_value2_i  input  32  combinational value of index2
- reg_write_enable_o  output  1  write-back strobe
- reg_write_index_o  output  4  write-back register
- reg_write_value_o  output  32  write-back data
- stall_o  output  1  hazard stall indicator

Behaviour:
- Reset (rst_i=0, async): PC=RESET_PC, all stage valids and write enables 0, all other registered outputs 0.
- Fetch:
  - Each unstalled cycle latches opcode = imem_data_i[47:32] and operand = imem_data_i[31:0], sets valid=1.
  - PC += 6 if opcode[15:8]==8'h01 (ldi.l), else PC += 2; 32-bit wrap.
- Decode (registered):
  - Form-1 instruction fields: op = opcode[15:8], rA = opcode[7:4], rB = opcode[3:0].
  - reg_read_index1_o = rA, reg_read_index2_o = rB.
  - Sets read-A/read-B flags per op, write_enable, write_index = rA, and passes the operand through.
- Execute: computes from reg_value1_i (A), reg_value2_i (B) and operand, then registers result, write index and write enable. These registered values drive the reg_write_* outputs, so write-back occurs one cycle after execute.
- Supported ops (all write rA; reads in brackets):
  - 01 ldi.l: rA=imm []
  - 02 mov: rA=B [B]
  - 05 add.l: A+B [A,B]
  - 26 and [A,B]
  - 27 lshr: A>>B[4:0] [A,B]
  - 28 ashl: A<<B[4:0] [A,B]
  - 29 sub.l: A-B [A,B]
  - 2a neg: 0-B [B]
  - 2b or [A,B]
  - 2c not: ~B [B]
  - 2d ashr: arithmetic A>>>B[4:0] [A,B]
  - 2e xor [A,B]
  - 2f mul.l [A,B] (optional, see below)
- All arithmetic is 32-bit modulo 2^32; no flags.
- 0x0f nop, any other form-1 op, any opcode with bit15=1, and invalid slots: no reads, no write (bubble).
- Hazard:
  - stall_o = (readA & xr_we & rA==xr_idx) | (readB & xr_we & rB==xr_idx), where xr_* are the current write-back registers.
  - On stall: PC, fetch register and decode register hold; execute latches a bubble (write_enable=0), while the current write-back still completes this cycle.
  - The stall lasts exactly one cycle per conflict.
- A stall never drops or duplicates instructions. Writes to the same register in consecutive instructions without an intervening read do not stall.
- Reset mid-stream discards all in-flight instructions immediately; fetch restarts at RESET_PC.

Optional Feature:
- Macro CPU_FDE_MUL_EN.
- Defined: op 2f mul.l writes low 32 bits of A*B.
- Undefined: op 2f is decoded as nop (no read, no write), and no multiplier is synthesized.

Test Plan:
- Reset: hold rst_i=0 → imem_address_o=0, reg_write_enable_o=0, stall_o=0. Release → address sequence 0, 2, 4 for nops.
- ldi.l: ldi.l r3,0x12345678 at 0 → next fetch at 6; three cycles later reg_write_enable_o=1, index 3, value 0x12345678.
- ALU: regfile r1=0xFFFFFFFF, r2=1, add.l r1,r2 → write r1=0; sub.l → 0xFFFFFFFE; ashr r1 by 4 → 0xFFFFFFFF; lshr by 4 → 0x0FFFFFFF.
- Hazard: ldi.l r4,5 followed by add.l r5,r4 → stall_o=1 for exactly one cycle when write-back of r4 coincides with decode of add. The add then reads 5; the PC holds during the stall.
- No false stall: ldi.l r4,5 followed by mov r6,r7 or nop → stall_o stays 0; ldi.l then ldi.l same register → no stall.
- Mul: mul.l with A=0x10000, B=0x10001 → 0x00010000 (low word) with CPU_FDE_MUL_EN; without the macro → no write.
